// File: rtl/reflet_int_ctrl.sv
// reflet_int_ctrl: prioritised interrupt controller for one reflet_cpu ext_int line.
// Each source is synchronised, then captured as an edge- or level-triggered pending
// bit. A per-channel mask selects which pending bits raise int_req. Software sees
// four registers in a small bus window starting at base_addr:
//   +0 PENDING (write-1-to-clear)
//   +1 MASK
//   +2 MODE (1 = edge)
//   +3 ID (read-only)
module reflet_int_ctrl #(
  parameter int wordsize = 8,
  parameter int channels = 8,
  parameter logic [wordsize-1:0] base_addr = 'h80
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [channels-1:0] irq_in,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                int_req
);

  localparam logic [wordsize-1:0] addr_pending = base_addr;
  localparam logic [wordsize-1:0] addr_mask    = base_addr + wordsize'(1);
  localparam logic [wordsize-1:0] addr_mode    = base_addr + wordsize'(2);
  localparam logic [wordsize-1:0] addr_id      = base_addr + wordsize'(3);

  logic [channels-1:0] s1_reg, s2_reg, s3_reg;
  logic [channels-1:0] pending_reg, pending_next;
  logic [channels-1:0] mask_reg, mode_reg;
  logic [channels-1:0] edge_set, clr_req, active;
  logic [wordsize-1:0] id_value, rd_data;
  logic                wr_pending, wr_mask, wr_mode;

  // Bus writes are only honoured while the CPU side is enabled.
  assign wr_pending = enable & write_en & (addr == addr_pending);
  assign wr_mask    = enable & write_en & (addr == addr_mask);
  assign wr_mode    = enable & write_en & (addr == addr_mode);

  assign edge_set = s2_reg & ~s3_reg;
  assign clr_req  = wr_pending ? data_in[channels-1:0] : '0;
  assign active   = pending_reg & mask_reg;

  // Per-channel capture: edge mode sets on a rising synchronised sample and holds
  // until cleared (a set in the same cycle as a clear wins); level mode simply
  // mirrors the synchronised input and ignores clears.
  generate
    for (genvar gi = 0; gi < channels; gi++) begin : g_capture
      assign pending_next[gi] = mode_reg[gi]
                              ? (edge_set[gi] | (pending_reg[gi] & ~clr_req[gi]))
                              : s2_reg[gi];
    end
  endgenerate

  // Two-flop synchroniser plus a history flop; runs regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= irq_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // Pending capture keeps running while enable is low so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_reg <= '0;
    else        pending_reg <= pending_next;
  end

  // Software-owned MASK and MODE registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg <= '0;
      mode_reg <= '1;
    end else begin
      if (wr_mask) mask_reg <= data_in[channels-1:0];
      if (wr_mode) mode_reg <= data_in[channels-1:0];
    end
  end

  // Lowest-numbered enabled pending channel wins; all-ones when none.
  always_comb begin
    id_value = '1;
    for (int i = channels - 1; i >= 0; i--) begin
      if (active[i]) id_value = wordsize'(i);
    end
  end

  // Read mux; unimplemented upper bits read as zero, outside the window reads 0
  // so the result can be OR-ed onto the shared bus.
  always_comb begin
    rd_data = '0;
    if (addr == addr_pending)   rd_data[channels-1:0] = pending_reg;
    else if (addr == addr_mask) rd_data[channels-1:0] = mask_reg;
    else if (addr == addr_mode) rd_data[channels-1:0] = mode_reg;
    else if (addr == addr_id)   rd_data = id_value;
  end

  // Registered bus read data and interrupt request; both hold while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      int_req  <= 1'b0;
    end else if (enable) begin
      data_out <= rd_data;
      int_req  <= |active;
    end
  end

endmodule

// File: doc/reflet_int_ctrl.md
# reflet_int_ctrl

Parametrised interrupt controller that sits between external interrupt sources and one `ext_int` line of `reflet_cpu`. It synchronises up to `channels` asynchronous request lines and captures each as an edge- or level-triggered pending bit. It applies a per-channel mask and drives a single prioritised request to the CPU. Software reads the pending, mask, mode and highest-priority ID registers, and clears pending bits, through a small memory-mapped window on the CPU data bus.

## Interface
- `wordsize`, 8: CPU data/address width; `channels` must be ≤ `wordsize`.
- `channels`, 8: number of interrupt source lines.
- `base_addr`, 8'h80: first of four consecutive register addresses.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset (one clock; the polarity and synchronicity are fixed).
- `enable` input 1: bus-side enable, same meaning as the CPU `enable`.
- `irq_in` input `channels`: asynchronous interrupt sources, active high.
- `addr` input `wordsize`: CPU address.
- `data_in` input `wordsize`: CPU write data.
- `write_en` input 1: CPU write strobe.
- `data_out` output `wordsize`: registered read data, 0 when not addressed, so it can be OR-ed onto the bus.
- `int_req` output 1: interrupt request to the CPU, connected to one `ext_int` bit.

## Operation
- Registers at `base_addr`+0..3. Bits ≥ `channels` read 0, writes to them are ignored.
  - PENDING (+0): read returns the pending bits. Writing 1 to a bit clears that bit; writing 0 has no effect.
  - MASK (+1): read/write; 1 = channel enabled.
  - MODE (+2): read/write; 1 = edge mode, 0 = level mode.
  - ID (+3): read-only. Returns the index of the lowest-numbered channel whose pending and mask bits are both 1, or all-ones if there is none.
- Each `irq_in` bit passes through a 2-flop synchroniser (`s1`, `s2`) plus a history flop `s3` for edge detection.
- Edge mode: a pending bit sets when `s2 & ~s3`. It stays set until a write-1 clear.
- Level mode: the pending bit follows `s2` every cycle. Write-1 clear has no effect.
- Simultaneous set and clear on the same channel in the same cycle: set wins.
- `int_req` is registered: the OR over all channels of (pending & mask), updated every cycle `enable` is 1.
- Priority for ID: channel 0 is highest, then ascending index.
- `enable` = 0:
  - Synchronisers and pending capture keep running, so no events are lost.
  - Register writes are ignored.
  - `data_out` and `int_req` hold their values.
- Changing the MODE of a channel from level to edge keeps the current pending value. The next capture follows the new mode.
- Masking a pending channel drops `int_req` (if no other channel is enabled and pending) without clearing the pending bit.

## Timing
- Reset values:
  - PENDING = 0, MASK = 0, MODE = all-ones.
  - `s1`/`s2`/`s3` = 0.
  - `int_req` = 0, `data_out` = 0.
- Reset asserted mid-operation clears everything immediately (asynchronously), with no wait for a clock edge.
- Capture latency, with `irq_in` rising before clock edge E0:
  - `s1`=1 at E0, `s2`=1 at E1.
  - Pending=1 at E2.
  - `int_req`=1 at E3.
- Clear latency: a write-1 to PENDING at edge W clears the bit at W. `int_req` falls at W+1 if no other channel is enabled and pending.
- Reads: for `addr` in the window at edge R, `data_out` carries the value sampled at R until the next edge. A read of PENDING in the same cycle as a clear returns the pre-clear value.
- Minimum detectable pulse is one full clock period high. In edge mode, a pulse must be low for at least one sample between events to register as two edges.

## Test plan
- Edge capture: reset low 5 cycles, then MASK=8'h01, pulse `irq_in[0]` high for 5 cycles → PENDING=8'h01 at E2, `int_req`=1 at E3, ID reads 0. Write PENDING=8'h01 → `int_req`=0 one cycle later.
- Priority: MASK=8'hFF, raise `irq_in[5]` then `irq_in[2]` → ID reads 5, then 2. Clear bit 2 → ID reads 5. Clear bit 5 → ID reads 8'hFF and `int_req`=0.
- Level mode: MODE=8'hFE, MASK=8'h01, hold `irq_in[0]` high → write-1 clear has no effect, `int_req` stays 1. Drop the input → PENDING bit 0 drops 2 cycles later and `int_req` drops 1 cycle after that.
- Enable low: `enable`=0, pulse `irq_in[1]`, write MASK=0 → PENDING bit 1 sets, MASK is unchanged, `int_req` held. `enable`=1 → `int_req`=1 on the next cycle.
- Set/clear collision: an edge on `irq_in[3]` reaches the capture stage in the same cycle as a write PENDING=8'h08 → PENDING bit 3 = 1 afterwards.
- Async reset mid-operation: with PENDING=8'h0F and `int_req`=1, pulse `reset` low between clock edges → all registers and outputs go to their reset values immediately.
